// File: rtl/dsm_model_core_if.sv
// Stimulus and observation bundle for dsm_model_core: NCO controls in, every
// intermediate stage of the transmit DAC path out.
interface dsm_model_core_if #(
  parameter int MASH_BW   = 4,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
);
  logic [ACC_WIDTH-1:0]      nco_step;
  logic                      nco_step_enable;
  logic                      dither_enable;
  logic signed [WIDTH-1:0]   tx_i_data;
  logic signed [WIDTH-1:0]   tx_q_data;
  logic signed [MASH_BW-1:0] mash_i_data;
  logic signed [MASH_BW-1:0] mash_q_data;
  logic                      dsm_i_data;
  logic                      dsm_q_data;
  logic                      upconverter_out;

  modport master (
    output nco_step, nco_step_enable, dither_enable,
    input  tx_i_data, tx_q_data, mash_i_data, mash_q_data,
           dsm_i_data, dsm_q_data, upconverter_out
  );

  modport slave (
    input  nco_step, nco_step_enable, dither_enable,
    output tx_i_data, tx_q_data, mash_i_data, mash_q_data,
           dsm_i_data, dsm_q_data, upconverter_out
  );
endinterface

// File: rtl/dsm_model_core.sv
// Transmit-side DAC path model: quadrature NCO with optional LFSR phase dither,
// per-channel MASH 1-1 and 1-bit first-order DSM, and an fs/4 upconverter.
module dsm_model_core #(
  parameter int MASH_BW        = 4,
  parameter int WIDTH          = 16,
  parameter int ACC_FRAC_WIDTH = 24,
  parameter int ACC_INT_WIDTH  = 8
) (
  input  logic aclk,
  input  logic rst,
  dsm_model_core_if.slave bus
);

  localparam int ACC_WIDTH = ACC_INT_WIDTH + ACC_FRAC_WIDTH;
  localparam int LUT_DEPTH = 2 ** ACC_INT_WIDTH;
  localparam int LFSR_BITS = (ACC_FRAC_WIDTH < 16) ? ACC_FRAC_WIDTH : 16;
  localparam real PI       = 3.14159265358979323846;

  // Elaboration-time sine via a Taylor series on the angle folded into [-pi, pi].
  function automatic logic signed [WIDTH-1:0] sin_entry(input int k);
    real x;
    real term;
    real sum;
    real v;
    int  rnd;
    x = 2.0 * PI * real'(k) / real'(LUT_DEPTH);
    if (x > PI) x = x - 2.0 * PI;
    term = x;
    sum  = x;
    for (int n = 1; n < 24; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    v = sum * real'((1 << (WIDTH - 1)) - 1);
    if (v >= 0.0) rnd = $rtoi(v + 0.5);
    else          rnd = -$rtoi(0.5 - v);
    return WIDTH'(rnd);
  endfunction

  logic signed [WIDTH-1:0] lut [LUT_DEPTH];

  for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
    localparam logic signed [WIDTH-1:0] ENTRY = sin_entry(gi);
    assign lut[gi] = ENTRY;
  end

  logic [ACC_WIDTH-1:0]      phase_reg;
  logic [15:0]               lfsr_reg;
  logic                      lfsr_fb;
  logic [ACC_WIDTH-1:0]      pd;
  logic [ACC_INT_WIDTH-1:0]  idx_q;
  logic [ACC_INT_WIDTH-1:0]  idx_i;
  logic [ACC_FRAC_WIDTH-1:0] unused_pd_frac;
  logic [WIDTH-1:0]          tx_reg [2];
  logic [1:0]                cnt_reg;
  logic                      up_reg;

  assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

  always_comb begin
    pd = phase_reg;
    if (bus.dither_enable) pd = phase_reg + ACC_WIDTH'(lfsr_reg[LFSR_BITS-1:0]);
  end

  assign {idx_q, unused_pd_frac} = pd;
  assign idx_i = idx_q + ACC_INT_WIDTH'(LUT_DEPTH / 4);

  always_ff @(posedge aclk) begin
    if (rst) begin
      phase_reg <= '0;
      lfsr_reg  <= 16'hACE1;
      tx_reg[0] <= '0;
      tx_reg[1] <= '0;
    end else begin
      if (bus.nco_step_enable) phase_reg <= phase_reg + bus.nco_step;
      lfsr_reg  <= {lfsr_fb, lfsr_reg[15:1]};
      tx_reg[0] <= lut[idx_i];
      tx_reg[1] <= lut[idx_q];
    end
  end

  // Channel 0 is I (cosine), channel 1 is Q (sine).
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [WIDTH-1:0]   xu;
    logic [WIDTH:0]     sum1;
    logic [WIDTH:0]     sum2;
    logic [WIDTH:0]     sum3;
    logic [WIDTH-1:0]   acc1_reg;
    logic [WIDTH-1:0]   acc2_reg;
    logic [WIDTH-1:0]   acc3_reg;
    logic               c2d_reg;
    logic [MASH_BW-1:0] mash_next;
    logic [MASH_BW-1:0] mash_reg;
    logic               dsm_reg;

    assign xu   = tx_reg[gi] ^ {1'b1, {(WIDTH-1){1'b0}}};
    assign sum1 = {1'b0, acc1_reg} + {1'b0, xu};
    assign sum2 = {1'b0, acc2_reg} + {1'b0, sum1[WIDTH-1:0]};
    assign sum3 = {1'b0, acc3_reg} + {1'b0, xu};
    // Modular arithmetic in MASH_BW bits yields the two's-complement result in -1..+2.
    assign mash_next = MASH_BW'(sum1[WIDTH]) + MASH_BW'(sum2[WIDTH]) - MASH_BW'(c2d_reg);

    always_ff @(posedge aclk) begin
      if (rst) begin
        acc1_reg <= '0;
        acc2_reg <= '0;
        acc3_reg <= '0;
        c2d_reg  <= 1'b0;
        mash_reg <= '0;
        dsm_reg  <= 1'b0;
      end else begin
        acc1_reg <= sum1[WIDTH-1:0];
        acc2_reg <= sum2[WIDTH-1:0];
        acc3_reg <= sum3[WIDTH-1:0];
        c2d_reg  <= sum2[WIDTH];
        mash_reg <= mash_next;
        dsm_reg  <= sum3[WIDTH];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      cnt_reg <= 2'd0;
      up_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_reg + 2'd1;
      case (cnt_reg)
        2'd0:    up_reg <= g_chan[0].dsm_reg;
        2'd1:    up_reg <= g_chan[1].dsm_reg;
        2'd2:    up_reg <= ~g_chan[0].dsm_reg;
        default: up_reg <= ~g_chan[1].dsm_reg;
      endcase
    end
  end

  assign bus.tx_i_data       = tx_reg[0];
  assign bus.tx_q_data       = tx_reg[1];
  assign bus.mash_i_data     = g_chan[0].mash_reg;
  assign bus.mash_q_data     = g_chan[1].mash_reg;
  assign bus.dsm_i_data      = g_chan[0].dsm_reg;
  assign bus.dsm_q_data      = g_chan[1].dsm_reg;
  assign bus.upconverter_out = up_reg;

endmodule

// File: tb/tb_dsm_model_core.sv
// Directed bench for dsm_model_core: reset, DC, tone, hold, upconverter and dither.
module tb_dsm_model_core;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  dsm_model_core_if #(.MASH_BW(4), .WIDTH(16), .ACC_WIDTH(32)) bus ();

  dsm_model_core #(
    .MASH_BW(4), .WIDTH(16), .ACC_FRAC_WIDTH(24), .ACC_INT_WIDTH(8)
  ) dut (
    .aclk (aclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  initial begin
    int mash_sum, range_bad, tx_bad, dsmq_bad, up_bad, up_ones, hits_obs, hits_exp;
    logic [15:0] lm;
    logic exp_up;

    // Reset with arbitrary inputs
    rst = 1'b1;
    bus.nco_step = 32'h1234_5678;
    bus.nco_step_enable = 1'b1;
    bus.dither_enable = 1'b1;
    repeat (3) tick();
    check("rst_tx_i", bus.tx_i_data, 0);
    check("rst_tx_q", bus.tx_q_data, 0);
    check("rst_mash_i", bus.mash_i_data, 0);
    check("rst_mash_q", bus.mash_q_data, 0);
    check("rst_dsm_i", bus.dsm_i_data, 0);
    check("rst_dsm_q", bus.dsm_q_data, 0);
    check("rst_up", bus.upconverter_out, 0);

    // DC: nco_step = 0
    rst = 1'b0;
    bus.nco_step = 32'd0;
    bus.dither_enable = 1'b0;
    tick();
    check("dc1_tx_i", bus.tx_i_data, 32767);
    check("dc1_tx_q", bus.tx_q_data, 0);
    check("dc1_mash_q", bus.mash_q_data, 0);
    check("dc1_dsm_q", bus.dsm_q_data, 0);
    check("dc1_up", bus.upconverter_out, 0);
    tick();
    check("dc2_mash_i", bus.mash_i_data, 1);
    check("dc2_mash_q", bus.mash_q_data, 1);
    check("dc2_dsm_i", bus.dsm_i_data, 1);
    check("dc2_dsm_q", bus.dsm_q_data, 1);
    check("dc2_up", bus.upconverter_out, 0);
    tick();
    check("dc3_mash_i", bus.mash_i_data, 2);
    check("dc3_mash_q", bus.mash_q_data, 1);
    check("dc3_dsm_q", bus.dsm_q_data, 0);
    check("dc3_up", bus.upconverter_out, 0);
    tick();
    check("dc4_mash_i", bus.mash_i_data, 0);
    check("dc4_mash_q", bus.mash_q_data, 0);
    check("dc4_dsm_q", bus.dsm_q_data, 1);
    check("dc4_up", bus.upconverter_out, 1);

    mash_sum = 0; range_bad = 0; tx_bad = 0; dsmq_bad = 0; up_bad = 0; up_ones = 0;
    for (int n = 5; n <= 4100; n++) begin
      tick();
      if (n <= 68) mash_sum += int'(bus.mash_q_data);
      if (bus.mash_q_data < -4'sd1 || bus.mash_q_data > 4'sd2 ||
          bus.mash_i_data < -4'sd1 || bus.mash_i_data > 4'sd2) range_bad++;
      if (bus.tx_i_data !== 16'sd32767 || bus.tx_q_data !== 16'sd0) tx_bad++;
      if (bus.dsm_q_data !== ((n % 2) == 0)) dsmq_bad++;
      exp_up = ((n % 4) == 1) || ((n % 4) == 0);
      if (bus.upconverter_out !== exp_up) up_bad++;
      if (bus.upconverter_out === 1'b1) up_ones++;
    end
    check("dc_mash_q_sum64", mash_sum, 32);
    check("dc_mash_range_bad", range_bad, 0);
    check("dc_tx_const_bad", tx_bad, 0);
    check("dc_dsm_q_toggle_bad", dsmq_bad, 0);
    check("up_pattern_bad", up_bad, 0);
    check("up_density_ok", (up_ones >= 2047 && up_ones <= 2049), 1);

    // Mid-operation reset, then tone with step 1<<20
    rst = 1'b1;
    tick();
    check("midrst_tx_i", bus.tx_i_data, 0);
    check("midrst_up", bus.upconverter_out, 0);
    rst = 1'b0;
    bus.nco_step = 32'h0010_0000;
    for (int n = 1; n <= 5135; n++) begin
      tick();
      case (n)
        1:    begin check("tone1_q", bus.tx_q_data, 0);      check("tone1_i", bus.tx_i_data, 32767); end
        17:   begin check("tone17_q", bus.tx_q_data, 804);   check("tone17_i", bus.tx_i_data, 32757); end
        513:  begin check("tone513_q", bus.tx_q_data, 23170); check("tone513_i", bus.tx_i_data, 23170); end
        1025: begin check("tone1025_q", bus.tx_q_data, 32767); check("tone1025_i", bus.tx_i_data, 0); end
        3073: begin check("tone3073_q", bus.tx_q_data, -32767); check("tone3073_i", bus.tx_i_data, 0); end
        4097: begin check("wrap4097_q", bus.tx_q_data, 0);   check("wrap4097_i", bus.tx_i_data, 32767); end
        5121: begin check("wrap5121_q", bus.tx_q_data, 32767); check("wrap5121_i", bus.tx_i_data, 0); end
        default: ;
      endcase
    end

    // Hold at the last phase of index 64
    bus.nco_step_enable = 1'b0;
    tx_bad = 0;
    repeat (100) begin
      tick();
      if (bus.tx_q_data !== 16'sd32767 || bus.tx_i_data !== 16'sd0) tx_bad++;
    end
    check("hold_const_bad", tx_bad, 0);
    bus.nco_step_enable = 1'b1;
    tick();
    check("resume1_q", bus.tx_q_data, 32767);
    check("resume1_i", bus.tx_i_data, 0);
    tick();
    check("resume2_q", bus.tx_q_data, 32757);
    check("resume2_i", bus.tx_i_data, -804);

    // Dither: phase parked just below index 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.nco_step = 32'h00FF_8000;
    bus.nco_step_enable = 1'b1;
    bus.dither_enable = 1'b1;
    tick();
    bus.nco_step_enable = 1'b0;
    lm = lfsr_step(16'hACE1);
    tx_bad = 0; hits_obs = 0; hits_exp = 0;
    for (int n = 2; n <= 41; n++) begin
      tick();
      if (lm[15]) hits_exp++;
      if (bus.tx_q_data === 16'sd804) hits_obs++;
      if (bus.tx_q_data !== (lm[15] ? 16'sd804 : 16'sd0) ||
          bus.tx_i_data !== (lm[15] ? 16'sd32757 : 16'sd32767)) tx_bad++;
      if (n == 3) check("dither_n3_q", bus.tx_q_data, 804);
      lm = lfsr_step(lm);
    end
    check("dither_sample_bad", tx_bad, 0);
    check("dither_hits", hits_obs, hits_exp);

    // Same run without dither is deterministic
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.nco_step_enable = 1'b1;
    bus.dither_enable = 1'b0;
    tick();
    bus.nco_step_enable = 1'b0;
    tx_bad = 0;
    repeat (40) begin
      tick();
      if (bus.tx_q_data !== 16'sd0 || bus.tx_i_data !== 16'sd32767) tx_bad++;
    end
    check("nodither_bad", tx_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsm_model_core.md
Name: dsm_model_core

Overview:
Single-clock transmit-side test model for the MASH 1-1 DAC path. A quadrature NCO with a phase accumulator and sine LUT produces I/Q samples. Each sample stream feeds a MASH 1-1 modulator with a multi-bit output and a first-order 1-bit sigma-delta. The 1-bit I/Q streams are upconverted at fs/4 into one serial bit. The block sits between stimulus and the DAC output model and exposes every intermediate stage for plotting.

Parameters:
MASH_BW, 4, width of the signed MASH output (must be >= 3)
WIDTH, 16, NCO sample width (signed two's complement)
ACC_FRAC_WIDTH, 24, fractional bits of the phase accumulator
ACC_INT_WIDTH, 8, LUT address bits; LUT_DEPTH = 2**ACC_INT_WIDTH; ACC_WIDTH = ACC_INT_WIDTH+ACC_FRAC_WIDTH

Ports:
aclk  in  1  sole clock; all registers on rising edge
rst  in  1  synchronous reset, active-high
nco_step  in  ACC_WIDTH  phase increment per cycle
nco_step_enable  in  1  1 = accumulate, 0 = hold phase
dither_enable  in  1  1 = add LFSR phase dither
tx_i_data  out  WIDTH  cosine sample, signed
tx_q_data  out  WIDTH  sine sample, signed
mash_i_data  out  MASH_BW  MASH 1-1 output for I, signed
mash_q_data  out  MASH_BW  MASH 1-1 output for Q, signed
dsm_i_data  out  1  1-bit first-order DSM of I
dsm_q_data  out  1  1-bit first-order DSM of Q
upconverter_out  out  1  fs/4 upconverted serial bit

Behaviour:
- Reset (rst=1 at an edge) clears all registers: phase, accumulators, c2 delay, upconverter counter and all outputs to 0. The LFSR is set to 16'hACE1. Reset asserted mid-operation restarts from this state on the next edge.
- Phase: if nco_step_enable, phase <= phase + nco_step (mod 2**ACC_WIDTH); otherwise phase holds.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. It advances every non-reset cycle.
- Dithered phase: pd = phase + zero-extend(LFSR[min(16,ACC_FRAC_WIDTH)-1:0]) when dither_enable=1; otherwise pd = phase.
- Index: idx = pd[ACC_WIDTH-1 -: ACC_INT_WIDTH].
- LUT entries: LUT[k] = round((2**(WIDTH-1)-1)*sin(2*pi*k/LUT_DEPTH)), constant, computed at elaboration.
- NCO outputs are registered with 1-cycle latency from phase: tx_q_data <= LUT[idx] and tx_i_data <= LUT[(idx + LUT_DEPTH/4) mod LUT_DEPTH].
- MASH 1-1, per channel, 1-cycle latency from the tx register:
  - Offset binary: xu = tx ^ (1<<(WIDTH-1)).
  - Stage 1: {c1,s1} = acc1 + xu; acc1 <= s1.
  - Stage 2: {c2,s2} = acc2 + s1; acc2 <= s2; c2d <= c2.
  - Output: mash <= c1 + c2 - c2d, sign-extended to MASH_BW. Range is -1..+2; no saturation is needed.
- 1-bit DSM, per channel:
  - {cb,sb} = acc3 + xu (WIDTH-bit accumulator); acc3 <= sb; dsm <= cb.
  - The 1-density equals xu / 2**WIDTH.
- Upconverter:
  - 2-bit counter increments every cycle and wraps 3->0.
  - upconverter_out <= dsm_i_data, dsm_q_data, ~dsm_i_data, ~dsm_q_data for counter values 0, 1, 2, 3 respectively.
- Total latency nco_step -> upconverter_out is 4 cycles (phase, tx, dsm, upconverter).
- nco_step = 0 gives a DC output. Phase wrap at 2**ACC_WIDTH is seamless.
- With dither_enable=0 the block is fully deterministic.

Test Plan:
- Reset: hold rst=1 for 3 cycles with arbitrary inputs -> every output equals 0. The first cycle after release gives tx_i_data=32767 and tx_q_data=0.
- DC, nco_step=0, enable=1, dither=0 -> tx_q_data=0 and tx_i_data=32767 forever. dsm_q_data toggles 0,1,0,1. Mean of mash_q_data over 64 cycles is 0.5; every value is in {-1,0,1,2}.
- Tone, nco_step=1<<20 -> phase period is 4096 cycles. tx_q_data=32767 at idx=64 (about cycle 1025 after release) and -32767 at idx=192. Waveform repeats exactly every 4096 cycles.
- Hold: drop nco_step_enable for 100 cycles mid-tone -> tx_i_data and tx_q_data stay constant. Sweep resumes from the same phase afterwards.
- Upconverter: force the DC case -> upconverter_out follows I,Q,~I,~Q on the counter phase. Over 4096 cycles its 1-density is 0.5 ± 1/4096.
- Dither: run the tone twice, once with dither_enable=1 -> some tx_q_data samples differ by one LUT step. With dither off, two runs match bit-exactly.
